// File: rtl/pz_frame_loader.sv
// pz_frame_loader: upstream feeder for the pole/zero accumulator stage.
//
// Accepts a frame header (zero count, pole count), then a serial stream of
// terms (zeros first, then poles) over a valid/ready handshake. The terms are
// packed into a flat register file that is presented, together with the
// counts, while `ready` is high. `ready` drives the accumulator enable.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   cfg_valid/nz/np      frame header; cfg_ready accepts, cfg_err pulses on reject
//   term_valid/data      term stream; term_ready while loading
//   frame_ack            consumer releases the held frame
//   abort                synchronous flush to idle (highest priority)
//   flat_pz              packed terms, slot i at [DATA_SIZE*i +: DATA_SIZE]
//   no_z, no_p           zero / pole counts, zero-extended
//   ready                a complete frame is held
module pz_frame_loader #(
    parameter int unsigned REG_FILE_SIZE = 8,
    parameter int unsigned DATA_SIZE     = 8
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               cfg_valid,
    input  logic [3:0]                         cfg_nz,
    input  logic [3:0]                         cfg_np,
    output logic                               cfg_ready,
    output logic                               cfg_err,
    input  logic                               term_valid,
    input  logic [DATA_SIZE-1:0]               term_data,
    output logic                               term_ready,
    input  logic                               frame_ack,
    input  logic                               abort,
    output logic [DATA_SIZE*REG_FILE_SIZE-1:0] flat_pz,
    output logic [31:0]                        no_z,
    output logic [31:0]                        no_p,
    output logic                               ready
);

    localparam int unsigned IdxW  = $clog2(REG_FILE_SIZE);
    localparam int unsigned FlatW = DATA_SIZE * REG_FILE_SIZE;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [FlatW-1:0]  flat_q, flat_d;
    logic [3:0]        nz_q, nz_d;
    logic [3:0]        np_q, np_d;
    logic [4:0]        total_q, total_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              cfg_err_q, cfg_err_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic [4:0]        cfg_total;
    logic              last_term;

    assign cfg_total = {1'b0, cfg_nz} + {1'b0, cfg_np};
    assign last_term = (32'(idx_q) + 32'd1) == 32'(total_q);

    always_comb begin
        state_d   = state_q;
        flat_d    = flat_q;
        nz_d      = nz_q;
        np_d      = np_q;
        total_d   = total_q;
        idx_d     = idx_q;
        cfg_err_d = 1'b0;

        if (abort) begin
            // Flush wins over everything; the held frame data is kept.
            state_d = StIdle;
            idx_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // cfg_ready_q stays low for the first cycle after reset.
                    if (cfg_valid && cfg_ready_q) begin
                        if (32'(cfg_total) > REG_FILE_SIZE) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            flat_d  = '0;
                            nz_d    = cfg_nz;
                            np_d    = cfg_np;
                            total_d = cfg_total;
                            idx_d   = '0;
                            state_d = (cfg_total == 5'd0) ? StHold : StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (term_valid) begin
                        flat_d[DATA_SIZE*idx_q +: DATA_SIZE] = term_data;
                        idx_d = idx_q + IdxW'(1);
                        if (last_term) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (frame_ack) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Registered so that no output is high while reset is asserted.
        cfg_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            flat_q      <= '0;
            nz_q        <= '0;
            np_q        <= '0;
            total_q     <= '0;
            idx_q       <= '0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flat_q      <= flat_d;
            nz_q        <= nz_d;
            np_q        <= np_d;
            total_q     <= total_d;
            idx_q       <= idx_d;
            cfg_err_q   <= cfg_err_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign cfg_err    = cfg_err_q;
    assign term_ready = (state_q == StLoad);
    assign ready      = (state_q == StHold);
    assign flat_pz    = flat_q;
    assign no_z       = 32'(nz_q);
    assign no_p       = 32'(np_q);

endmodule

// File: doc/pz_frame_loader.md
Name: pz_frame_loader

Overview:
- Upstream feeder for the pole/zero accumulator stage.
- Accepts a frame header (zero count, pole count), then a serial stream of terms over a valid/ready handshake. Zeros arrive first, then poles.
- Packs the terms into a flat register file and presents the file with its counts, holding them stable.
- Raises `ready` while a complete frame is held. `ready` directly drives the accumulator's enable.

Parameters:
- REG_FILE_SIZE, 8, number of term slots; power of two, ≥4.
- DATA_SIZE, 8, bits per term.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  frame header valid.
- cfg_nz  input  4  number of zero terms in the frame.
- cfg_np  input  4  number of pole terms in the frame.
- cfg_ready  output  1  header accepted this cycle if cfg_valid is also high.
- cfg_err  output  1  one-cycle pulse: header rejected.
- term_valid  input  1  term data valid.
- term_data  input  DATA_SIZE  term value.
- term_ready  output  1  loader can accept a term.
- frame_ack  input  1  consumer done with the held frame.
- abort  input  1  synchronous flush to IDLE.
- flat_pz  output  DATA_SIZE*REG_FILE_SIZE  packed terms; slot i occupies bits [DATA_SIZE*i +: DATA_SIZE].
- no_z  output  32  zero count, zero-extended from 4 bits.
- no_p  output  32  pole count, zero-extended from 4 bits.
- ready  output  1  complete frame held.

Behaviour:
- Reset (async, resetn low): state=IDLE; flat_pz=0, no_z=0, no_p=0, ready=0, cfg_err=0, internal index=0. term_ready=0. cfg_ready=1 once resetn is released.
- All outputs are registered or decoded from state only. No input-to-output combinational path.
- IDLE, header handling (cfg_ready=1, term_ready=0, ready=0). On cfg_valid, let total = cfg_nz + cfg_np as a 5-bit sum:
  - total > REG_FILE_SIZE: cfg_err=1 for exactly the next cycle. Remain in IDLE. flat_pz, no_z and no_p keep their previous contents.
  - total == 0: clear flat_pz, latch no_z=no_p=0, go directly to HOLD. ready=1 the next cycle.
  - otherwise: clear flat_pz, latch no_z/no_p, index=0, go to LOAD.
- LOAD, term intake (term_ready=1, cfg_ready=0):
  - Each cycle with term_valid high: write term_data into slot index, then index+1.
  - Acceptance of the term with index == total-1 moves the block to HOLD. ready=1 on the cycle after that acceptance edge.
  - Slots ≥ total stay 0.
  - No term is written while term_valid is low. Gaps of any length are allowed.
- HOLD, frame presentation (ready=1, term_ready=0, cfg_ready=0): flat_pz, no_z and no_p are held constant.
  - frame_ack moves the block to IDLE. ready=0 the next cycle.
  - flat_pz and counts remain unchanged until the next accepted header.
- abort, any state: has highest priority. Next state is IDLE and index=0. ready, cfg_err and term_ready go to 0 next cycle. flat_pz and counts are not cleared.
  - An abort in the same cycle as a term acceptance discards that term: no write.
- Simultaneous-event priority: abort > cfg/term/ack handling.
  - cfg_valid in LOAD or HOLD is ignored (cfg_ready=0). The source must hold it until accepted.
  - frame_ack outside HOLD is ignored.
- Reset asserted mid-LOAD or mid-HOLD immediately returns all outputs to reset values. A partially loaded frame is lost.
- Throughput: a header plus N terms occupies 1+N cycles with no back-pressure. ready rises at cycle 1+N relative to the header acceptance edge.

Test Plan:
- Reset, then header nz=2, np=1, then terms 0x10, 0x20, 0x05 back-to-back. Required:
  - ready=1 on the cycle after the third acceptance.
  - flat_pz = 0x0000000000052010; no_z=2, no_p=1.
  - term_ready=0 while in HOLD.
- Same frame with term_valid gaps of 3 cycles between terms. Required: identical flat_pz; ready asserts only after the last accepted term.
- Header nz=5, np=4 (total 9 > 8). Required: cfg_err high for exactly 1 cycle; state stays IDLE; previously held flat_pz unchanged.
- Header nz=0, np=0. Required: ready=1 the next cycle; flat_pz=0; no_z=no_p=0.
- Load nz=8, np=0 with terms 1..8, then frame_ack. Required:
  - During HOLD, flat_pz = 0x0807060504030201.
  - ready=0 one cycle after the ack; cfg_ready=1.
  - A new header nz=1, np=0 followed by term 0xFF yields flat_pz = 0x00000000000000FF.
- Abort after 2 of 4 terms, and separately assert resetn low mid-LOAD. Required:
  - Abort: returns to IDLE, the abort-cycle term is not written, ready never asserts.
  - Reset: all outputs are 0 immediately. A subsequent complete frame loads correctly.
